// File: rtl/dual_regfile.sv
// Dual-lane writeback register file: 15 GPRs (r0..r14) plus a virtual r15
// that reads as PC+8. Two write lanes retire per cycle (lane 2 is younger),
// four combinational read ports with same-cycle write-through bypass, a PC
// redirect request when a lane writes back to the PC, and a sticky flag that
// records any cycle in which both lanes wrote the same GPR.
module dual_regfile #(
    parameter int D_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    // Lane-1 writeback (older instruction)
    input  logic               i_RegWrite1W,
    input  logic               i_PCSrc1W,
    input  logic [3:0]         i_WA1W,
    input  logic [D_WIDTH-1:0] i_Result1W,
    // Lane-2 writeback (younger instruction)
    input  logic               i_RegWrite2W,
    input  logic               i_PCSrc2W,
    input  logic [3:0]         i_WA2W,
    input  logic [D_WIDTH-1:0] i_Result2W,
    // Decode read addresses
    input  logic [3:0]         i_RA1D,
    input  logic [3:0]         i_RA2D,
    input  logic [3:0]         i_RA3D,
    input  logic [3:0]         i_RA4D,
    input  logic [D_WIDTH-1:0] i_PC8,
    // Read data
    output logic [D_WIDTH-1:0] o_RD1D,
    output logic [D_WIDTH-1:0] o_RD2D,
    output logic [D_WIDTH-1:0] o_RD3D,
    output logic [D_WIDTH-1:0] o_RD4D,
    // PC redirect
    output logic               o_PCRedirect,
    output logic [D_WIDTH-1:0] o_PCTarget,
    output logic               o_WrConflict
);

    localparam logic [3:0] PC_ADDR = 4'd15;
    localparam int         NUM_GPR = 15;
    localparam int         NUM_RD  = 4;

    logic [D_WIDTH-1:0] regs_q [NUM_GPR];
    logic [D_WIDTH-1:0] regs_d [NUM_GPR];
    logic               wr_conflict_q;
    logic               wr_conflict_d;

    logic               gpr_we1;
    logic               gpr_we2;
    logic               redir1;
    logic               redir2;

    // 16-entry read view: r0..r14 from storage, r15 is PC+8.
    logic [D_WIDTH-1:0] rd_view [16];
    logic [3:0]         rd_addr [NUM_RD];
    logic [D_WIDTH-1:0] rd_data [NUM_RD];

    // Decode which lanes perform a real GPR write (r15 has no storage).
    always_comb begin
        gpr_we1 = i_RegWrite1W && (i_WA1W != PC_ADDR);
        gpr_we2 = i_RegWrite2W && (i_WA2W != PC_ADDR);
        redir1  = i_RegWrite1W && i_PCSrc1W;
        redir2  = i_RegWrite2W && i_PCSrc2W;
    end

    // Next-state of the GPR array; lane 2 overrides lane 1 on the same address.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (prevents latch inference).
        for (int i = 0; i < NUM_GPR; i++) begin
            regs_d[i] = regs_q[i];
            if (gpr_we1 && (i_WA1W == 4'(i))) regs_d[i] = i_Result1W;
            if (gpr_we2 && (i_WA2W == 4'(i))) regs_d[i] = i_Result2W;
        end
        wr_conflict_d = wr_conflict_q || (gpr_we1 && gpr_we2 && (i_WA1W == i_WA2W));
    end

    // GPR storage and sticky conflict flag; asynchronous clear wins over writes.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the architectural reset value of every GPR is zero, so the array is built from resettable flops rather than a RAM macro.
        if (!rst_n) begin
            for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= '0;
            wr_conflict_q <= 1'b0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
            for (int i = 0; i < NUM_GPR; i++) regs_q[i] <= regs_d[i];
            wr_conflict_q <= wr_conflict_d;
        end
    end

    // Assemble the read view and the per-port addresses.
    always_comb begin
        for (int i = 0; i < NUM_GPR; i++) rd_view[i] = regs_q[i];
        rd_view[15] = i_PC8;
        rd_addr[0]  = i_RA1D;
        rd_addr[1]  = i_RA2D;
        rd_addr[2]  = i_RA3D;
        rd_addr[3]  = i_RA4D;
    end

    // Read ports with write-through bypass; the younger lane is applied last so it wins.
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            rd_data[p] = rd_view[rd_addr[p]];
            if (gpr_we1 && (i_WA1W == rd_addr[p])) rd_data[p] = i_Result1W;
            if (gpr_we2 && (i_WA2W == rd_addr[p])) rd_data[p] = i_Result2W;
        end
    end

    // PC redirect: the older branch (lane 1) takes priority.
    always_comb begin
        o_PCRedirect = redir1 || redir2;
        o_PCTarget   = '0;
        if (redir1)      o_PCTarget = i_Result1W;
        else if (redir2) o_PCTarget = i_Result2W;
    end

    assign o_RD1D       = rd_data[0];
    assign o_RD2D       = rd_data[1];
    assign o_RD3D       = rd_data[2];
    assign o_RD4D       = rd_data[3];
    assign o_WrConflict = wr_conflict_q;

endmodule

// File: doc/dual_regfile.md
DUAL_REGFILE -- requirements
Module: dual_regfile

Interface
REQ-001 D_WIDTH, 32 (shared `D_WIDTH), datapath width of every register, result, read and target bus.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_RegWrite1W  in  1  lane-1 writeback enable.
REQ-005 i_PCSrc1W  in  1  lane-1 writeback targets PC (branch/PC write).
REQ-006 i_WA1W  in  4  lane-1 write address.
REQ-007 i_Result1W  in  D_WIDTH  lane-1 write data.
REQ-008 i_RegWrite2W, i_PCSrc2W, i_WA2W, i_Result2W  in  1/1/4/D_WIDTH  lane-2 equivalents; lane 2 is the younger instruction.
REQ-009 i_RA1D, i_RA2D  in  4 each  lane-1 decode read addresses.
REQ-010 i_RA3D, i_RA4D  in  4 each  lane-2 decode read addresses.
REQ-011 i_PC8  in  D_WIDTH  value returned for reads of r15 (PC+8).
REQ-012 o_RD1D..o_RD4D  out  D_WIDTH each  read data for i_RA1D..i_RA4D.
REQ-013 o_PCRedirect  out  1  PC redirect request this cycle.
REQ-014 o_PCTarget  out  D_WIDTH  redirect target.
REQ-015 o_WrConflict  out  1  sticky flag: both lanes wrote the same GPR in one cycle since reset.

Function
REQ-016 Storage: 15 GPRs r0..r14, D_WIDTH each; r15 has no storage.
REQ-017 Lane-n write: at rising clk, if i_RegWriten=1 and i_WAn!=15, r[i_WAn] <= i_Resultn.
REQ-018 Writes with i_WAn=15 never modify any GPR, regardless of i_PCSrcn.
REQ-019 Same-address dual write (both enables, equal address, !=15): lane-2 data stored; lane-1 data discarded.
REQ-020 Different-address dual write: both stored in the same edge.
REQ-021 Reads combinational, zero latency: RA=15 -> i_PC8; else stored r[RA], subject to REQ-022.
REQ-022 Write-through bypass: if a read address equals a write address of a valid GPR write in the same cycle, read returns the write data; lane-2 write takes precedence over lane-1 when both match.
REQ-023 o_PCRedirect = (i_RegWrite1W & i_PCSrc1W) | (i_RegWrite2W & i_PCSrc2W); combinational.
REQ-024 o_PCTarget = i_Result1W when lane-1 redirect is valid (older branch wins), else i_Result2W when lane-2 redirect is valid, else 0.
REQ-025 PCSrc writes to a GPR address (WA!=15) perform the normal GPR write per REQ-017 and also redirect per REQ-023.
REQ-026 o_WrConflict set at rising clk on a REQ-019 event; remains 1 until reset.
REQ-027 No stalls, no handshake: each cycle's writeback inputs are consumed in that cycle.

Reset
REQ-028 rst_n=0 asynchronously clears r0..r14 to 0 and o_WrConflict to 0, independent of clk.
REQ-029 During reset, writes are ignored; reads of r0..r14 return 0 except bypassed data per REQ-022, which is still combinational; r15 returns i_PC8.
REQ-030 Reset asserted mid-write cycle: reset wins; register holds 0 after release until next write.
REQ-031 First write takes effect on the first rising clk with rst_n=1.

Verification
REQ-032 Lane-1 write r3=0x0000_00AA, next cycle RA1=3 -> o_RD1D=0x0000_00AA; RA2=15, i_PC8=0x108 -> o_RD2D=0x108.
REQ-033 Both lanes write r5 (0x11 lane1, 0x22 lane2) -> same cycle RA3=5 reads 0x22 (bypass); next cycle r5=0x22; o_WrConflict=1 and stays 1.
REQ-034 Lane1 writes r1=0x1, lane2 writes r2=0x2 same edge -> next cycle RA1=1 ->0x1, RA4=2 ->0x2; o_WrConflict unchanged 0.
REQ-035 Both lanes RegWrite+PCSrc WA=15, results 0x400/0x800 -> o_PCRedirect=1, o_PCTarget=0x400, no GPR changes; lane-2 only -> 0x800.
REQ-036 Write r7=0xFFFF_FFFF, pulse rst_n=0 between clk edges -> RA1=7 reads 0 immediately; o_WrConflict=0.
REQ-037 Write with RegWrite=0, WA=4, Result=0x55 -> r4 unchanged, no bypass, o_PCRedirect=0 even with PCSrc=1.
